// File: rtl/nand_pbuf_pkg.sv
// Shared types and constants for the NAND page-buffer controller.
// Page size equals 2**ADDR_W, so the column wrap is a natural roll-over.
`timescale 1ns/1ps
package nand_pbuf_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int PAGE_BYTES = 2048;

  localparam logic DIR_LOAD = 1'b0;
  localparam logic DIR_PROG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PROG = 2'd2,
    DONE = 2'd3
  } pbuf_state_t;

  function automatic logic [ADDR_W-1:0] col_next(input logic [ADDR_W-1:0] c);
    return (c == ADDR_W'(PAGE_BYTES - 1)) ? '0 : c + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > (ADDR_W+1)'(PAGE_BYTES)) ? (ADDR_W+1)'(PAGE_BYTES) : l;
  endfunction

endpackage

// File: rtl/nand_page_buffer_ctrl_host_port.sv
// Host column pointer and buffer port A drive; read data returns one cycle after the strobe.
// Strobes arriving while host_ready is low are dropped and leave the pointer untouched.
`timescale 1ns/1ps
module pbuf_host_port
  import nand_pbuf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              host_ready,
  input  logic              host_col_ld,
  input  logic [ADDR_W-1:0] host_col,
  input  logic              host_wr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_rd,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_a,
  output logic              ram_en_a
);

  logic [ADDR_W-1:0] col_ptr;
  logic [ADDR_W-1:0] acc_col;
  logic              acc_wr;
  logic              acc_rd;

  // A same-cycle column load redirects the access to host_col.
  always_comb begin
    acc_col = host_col_ld ? host_col : col_ptr;
    acc_wr  = host_ready && !reset && host_wr;
    acc_rd  = host_ready && !reset && host_rd && !host_wr;
  end

  assign ram_en_a   = acc_wr || acc_rd;
  assign ram_we_a   = acc_wr;
  assign ram_addr_a = (acc_wr || acc_rd) ? acc_col : '0;
  assign ram_data_a = acc_wr ? host_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_ptr     <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= acc_rd;
      if (acc_wr || acc_rd)
        col_ptr <= col_next(acc_col);
      else if (host_ready && host_col_ld)
        col_ptr <= host_col;
    end
  end

endmodule

// File: rtl/nand_page_buffer_ctrl.sv
// Page-buffer sequencer: host byte access on port A, page load/program engine on port B.
// Optional transfer checksum is built only when PBUF_XFER_CSUM_EN is defined.
`timescale 1ns/1ps
module nand_page_buffer_ctrl
  import nand_pbuf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              host_col_ld,
  input  logic [ADDR_W-1:0] host_col,
  input  logic              host_wr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_rd,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_ready,
  input  logic              xfer_start,
  input  logic              xfer_dir,
  input  logic [ADDR_W:0]   xfer_len,
  output logic              busy,
  output logic              xfer_done,
  output logic [DATA_W-1:0] xfer_csum,
  input  logic              arr_in_valid,
  input  logic [DATA_W-1:0] arr_in_data,
  output logic              arr_out_valid,
  output logic [DATA_W-1:0] arr_out_data,
  input  logic              arr_out_ready,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  output logic              ram_en_a,
  output logic              ram_en_b,
  input  logic [DATA_W-1:0] ram_q_a,
  input  logic [DATA_W-1:0] ram_q_b
);

  pbuf_state_t     state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] bcnt;
  logic            busy_q;
  logic            done_q;
  logic            out_vld;
  logic            ld_beat;
  logic            pg_issue;
  logic            pg_accept;
  logic            start_acc;

  assign host_ready    = !busy_q;
  assign busy          = busy_q;
  assign xfer_done     = done_q;
  assign arr_out_valid = out_vld;
  assign arr_out_data  = ram_q_b;
  assign host_rdata    = ram_q_a;

  pbuf_host_port u_host (
    .clk         (clk),
    .reset       (reset),
    .host_ready  (host_ready),
    .host_col_ld (host_col_ld),
    .host_col    (host_col),
    .host_wr     (host_wr),
    .host_wdata  (host_wdata),
    .host_rd     (host_rd),
    .host_rvalid (host_rvalid),
    .ram_addr_a  (ram_addr_a),
    .ram_data_a  (ram_data_a),
    .ram_we_a    (ram_we_a),
    .ram_en_a    (ram_en_a)
  );

  // In PROG, bcnt counts issued reads; a held output byte blocks further issue.
  always_comb begin
    start_acc = (state == IDLE) && xfer_start;
    ld_beat   = (state == LOAD) && arr_in_valid && !reset;
    pg_issue  = (state == PROG) && (bcnt < len_q) && (!out_vld || arr_out_ready) && !reset;
    pg_accept = (state == PROG) && out_vld && arr_out_ready;
  end

  assign ram_en_b   = ld_beat || pg_issue;
  assign ram_we_b   = ld_beat;
  assign ram_addr_b = (ld_beat || pg_issue) ? bcnt[ADDR_W-1:0] : '0;
  assign ram_data_b = ld_beat ? arr_in_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      bcnt    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_start) begin
            len_q  <= clamp_len(xfer_len);
            bcnt   <= '0;
            busy_q <= 1'b1;
            if (xfer_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= (xfer_dir == DIR_PROG) ? PROG : LOAD;
            end
          end
        end
        LOAD: begin
          if (ld_beat) begin
            bcnt <= bcnt + (ADDR_W+1)'(1);
            if (bcnt + (ADDR_W+1)'(1) == len_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        PROG: begin
          if (pg_issue) begin
            bcnt    <= bcnt + (ADDR_W+1)'(1);
            out_vld <= 1'b1;
          end else if (pg_accept) begin
            out_vld <= 1'b0;
          end
          if (pg_accept && (bcnt == len_q)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PBUF_XFER_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset)
      csum_q <= '0;
    else if (start_acc)
      csum_q <= '0;
    else if (ld_beat)
      csum_q <= csum_q ^ arr_in_data;
    else if (pg_accept)
      csum_q <= csum_q ^ ram_q_b;
  end

  assign xfer_csum = csum_q;
`else
  assign xfer_csum = '0;
`endif

endmodule

// File: tb/tb_nand_page_buffer_ctrl.sv
// Self-checking bench: buffer RAM model, host table, directed transfer corners, randomized traffic.
`timescale 1ns/1ps
module tb_nand_page_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_col_ld;
  logic [10:0] host_col;
  logic        host_wr;
  logic [7:0]  host_wdata;
  logic        host_rd;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        host_ready;
  logic        xfer_start;
  logic        xfer_dir;
  logic [11:0] xfer_len;
  logic        busy;
  logic        xfer_done;
  logic [7:0]  xfer_csum;
  logic        arr_in_valid;
  logic [7:0]  arr_in_data;
  logic        arr_out_valid;
  logic [7:0]  arr_out_data;
  logic        arr_out_ready;
  logic [10:0] ram_addr_a, ram_addr_b;
  logic [7:0]  ram_data_a, ram_data_b;
  logic        ram_we_a, ram_we_b, ram_en_a, ram_en_b;
  logic [7:0]  ram_q_a, ram_q_b;

  always #5 clk = ~clk;

  nand_page_buffer_ctrl dut (
    .clk(clk), .reset(reset),
    .host_col_ld(host_col_ld), .host_col(host_col), .host_wr(host_wr),
    .host_wdata(host_wdata), .host_rd(host_rd), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_ready(host_ready),
    .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_len(xfer_len),
    .busy(busy), .xfer_done(xfer_done), .xfer_csum(xfer_csum),
    .arr_in_valid(arr_in_valid), .arr_in_data(arr_in_data),
    .arr_out_valid(arr_out_valid), .arr_out_data(arr_out_data),
    .arr_out_ready(arr_out_ready),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_en_a(ram_en_a), .ram_en_b(ram_en_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // Dual-port EBR: synchronous read-before-write, output held while disabled.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      ram_q_a <= mem[ram_addr_a];
    end
    if (ram_en_b) begin
      if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
      ram_q_b <= mem[ram_addr_b];
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [0:2047];
  int         ref_ptr = 0;
  bit         exp_rv = 0;
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] load_q[$];

  typedef struct {
    bit ld; int col; bit wr; logic [7:0] wd; bit rd;
    bit e_en; bit e_we; int e_addr; bit e_rv; logic [7:0] e_rd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    host_col_ld = 0; host_col = '0; host_wr = 0; host_wdata = '0; host_rd = 0;
    xfer_start = 0; xfer_dir = 0; xfer_len = '0;
    arr_in_valid = 0; arr_in_data = '0; arr_out_ready = 0;
  endtask

  // One idle-state host cycle checked against the pointer/byte model.
  task automatic host_op(input bit ld, input int col, input bit wr, input logic [7:0] wd, input bit rd);
    int a;
    host_col_ld = ld; host_col = 11'(col); host_wr = wr; host_wdata = wd; host_rd = rd;
    @(negedge clk);
    chk("host_rvalid", host_rvalid, exp_rv);
    if (exp_rv) chk("host_rdata", host_rdata, exp_rd);
    a = ld ? col : ref_ptr;
    chk("host_en_a", ram_en_a, wr || rd);
    if (wr || rd) chk("host_addr_a", ram_addr_a, a);
    exp_rv = 0;
    if (wr) ref_mem[a] = wd;
    else if (rd) begin exp_rv = 1; exp_rd = ref_mem[a]; end
    if (wr || rd) ref_ptr = (a + 1) % 2048;
    else if (ld) ref_ptr = col;
    cyc();
    clear_inputs();
  endtask

  task automatic host_rand(input int n);
    for (int i = 0; i < n; i++)
      host_op($urandom_range(0, 4) == 0, $urandom_range(0, 2047), $urandom_range(0, 2) == 0,
              8'($urandom), $urandom_range(0, 2) == 0);
    host_op(0, 0, 0, 8'h00, 0);
  endtask

  // mode 0: random valid/ready, 1: always on, 2: pattern bit per cycle (on after bit 31).
  task automatic run_xfer(input bit dir, input int len, input int mode, input logic [31:0] pat,
                          output int done_cyc);
    int eff, k, enb, budget, hc;
    bit fin, on;
    logic [7:0] cs;
    logic [7:0] exp_q[$];
    eff = (len > 2048) ? 2048 : len;
    k = 0; enb = 0; fin = 0; cs = 8'h00; done_cyc = -1;
    xfer_start = 1; xfer_dir = dir; xfer_len = 12'(len);
    if (mode == 0 && $urandom_range(0, 1) == 1) begin
      hc = $urandom_range(0, 2047);
      host_col_ld = 1; host_col = 11'(hc); host_wr = 1; host_wdata = 8'($urandom);
    end else hc = -1;
    @(negedge clk);
    chk("start_ready", host_ready, 1);
    chk("start_host_en_a", ram_en_a, hc >= 0);
    if (hc >= 0) begin ref_mem[hc] = host_wdata; ref_ptr = (hc + 1) % 2048; end
    if (dir) for (int i = 0; i < eff; i++) exp_q.push_back(ref_mem[i]);
    else     for (int i = 0; i < eff; i++) exp_q.push_back(load_q[i]);
    cyc();
    clear_inputs();
    budget = eff * 12 + 40;
    for (int c = 0; c < budget && !fin; c++) begin
      on = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? 1'b1 : (c < 32 ? pat[c] : 1'b1);
      if (!dir) begin
        arr_in_valid = on && (k < eff);
        arr_in_data  = (k < eff) ? exp_q[k] : 8'($urandom);
      end else arr_out_ready = on;
      host_wr = $urandom_range(0, 1); host_rd = $urandom_range(0, 1);
      host_col_ld = $urandom_range(0, 1); host_col = 11'($urandom);
      xfer_start = $urandom_range(0, 3) == 0; xfer_dir = ~dir; xfer_len = 12'($urandom_range(1, 9));
      @(negedge clk);
      chk("lock_ready", host_ready, 0);
      chk("lock_en_a", ram_en_a, 0);
      if (ram_en_b) enb++;
      if (!dir && arr_in_valid) begin
        chk("load_we_b", ram_we_b, 1);
        chk("load_addr_b", ram_addr_b, k);
        chk("load_data_b", ram_data_b, exp_q[k]);
        cs ^= exp_q[k]; k++;
      end
      if (dir && arr_out_valid && arr_out_ready) begin
        if (k < eff) begin chk("prog_data", arr_out_data, exp_q[k]); cs ^= exp_q[k]; end
        else chk("prog_extra_byte", k + 1, eff);
        k++;
      end
      if (xfer_done) begin fin = 1; done_cyc = c; end
      cyc();
    end
    clear_inputs();
    if (!fin) chk("xfer_timeout", 0, 1);
    @(negedge clk);
    chk("done_single_pulse", xfer_done, 0);
    chk("busy_after", busy, 0);
    chk("ready_after", host_ready, 1);
    chk("xfer_bytes", k, eff);
    chk("en_b_count", enb, eff);
`ifdef PBUF_XFER_CSUM_EN
    chk("csum", xfer_csum, cs);
`else
    chk("csum_off", xfer_csum, 0);
`endif
    if (!dir) begin
      int bad = 0;
      for (int i = 0; i < eff; i++) begin
        ref_mem[i] = exp_q[i];
        if (mem[i] !== ref_mem[i]) bad++;
      end
      chk("load_mem", bad, 0);
    end
    exp_rv = 0;
    cyc();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    clear_inputs();
    reset = 1;
    repeat (3) cyc();
    reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_ready", host_ready, 1);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_out_valid", arr_out_valid, 0);
    chk("rst_csum", xfer_csum, 0);
    chk("rst_en_a", ram_en_a, 0);
    chk("rst_en_b", ram_en_b, 0);
    cyc();

    // Column wrap, auto-increment, 1-cycle read latency, write-wins collision.
    tbl[0]  = '{1'b1, 'h7FE, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 'h7FE, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 0,     1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 'h7FF, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 0,     1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 'h000, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 'h7FE, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 'h7FE, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 0,     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 'h7FF, 1'b1, 8'hA1};
    tbl[5]  = '{1'b0, 0,     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 'h000, 1'b1, 8'hA2};
    tbl[6]  = '{1'b0, 0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0,     1'b1, 8'hA3};
    tbl[7]  = '{1'b0, 0,     1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 'h001, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0,     1'b0, 8'h00};
    tbl[9]  = '{1'b1, 'h001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0,     1'b0, 8'h00};
    tbl[10] = '{1'b0, 0,     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 'h001, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0,     1'b1, 8'h5A};
    for (int i = 0; i < 12; i++) begin
      host_col_ld = tbl[i].ld; host_col = 11'(tbl[i].col); host_wr = tbl[i].wr;
      host_wdata = tbl[i].wd; host_rd = tbl[i].rd;
      @(negedge clk);
      chk("tbl_en_a", ram_en_a, tbl[i].e_en);
      chk("tbl_we_a", ram_we_a, tbl[i].e_we);
      if (tbl[i].e_en) chk("tbl_addr_a", ram_addr_a, tbl[i].e_addr);
      chk("tbl_rvalid", host_rvalid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk("tbl_rdata", host_rdata, tbl[i].e_rd);
      cyc();
      clear_inputs();
    end

    // Fill the whole page through the host port so the model is fully defined.
    exp_rv = 0;
    host_op(1, 0, 1, 8'($urandom), 0);
    for (int i = 1; i < 2048; i++) host_op(0, 0, 1, 8'($urandom), 0);
    chk("preload_ptr_wrapped", ref_ptr, 0);
    host_rand(30);

    load_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(0, 4, 2, 32'hFFFF_FFF3, dc);
    chk("load4_done_cyc", dc, 6);

    host_op(1, 0, 1, 8'h10, 0);
    host_op(0, 0, 1, 8'h20, 0);
    host_op(0, 0, 1, 8'h30, 0);
    run_xfer(1, 3, 2, 32'hFFFF_FFC7, dc);
    chk("prog3_done_cyc", dc, 7);

    run_xfer(0, 0, 1, 32'h0, dc);
    chk("len0_done_cyc", dc, 0);

    load_q.delete();
    for (int i = 0; i < 2048; i++) load_q.push_back(8'($urandom));
    run_xfer(0, 4095, 1, 32'h0, dc);
    chk("load_clamp_done_cyc", dc, 2048);

    run_xfer(1, 5, 1, 32'h0, dc);
    chk("prog5_done_cyc", dc, 6);
    run_xfer(1, 2048, 0, 32'h0, dc);
    host_rand(20);

    for (int it = 0; it < 25; it++) begin
      int len;
      bit dir;
      dir = $urandom_range(0, 1);
      len = ($urandom_range(0, 15) == 0) ? $urandom_range(2000, 4095) : $urandom_range(0, 48);
      load_q.delete();
      for (int i = 0; i < 2048; i++) load_q.push_back(8'($urandom));
      run_xfer(dir, len, 0, 32'h0, dc);
      host_rand($urandom_range(5, 20));
    end

    // Reset in the middle of a program transfer.
    xfer_start = 1; xfer_dir = 1; xfer_len = 12'd100;
    cyc();
    clear_inputs();
    arr_out_ready = 1;
    repeat (10) cyc();
    @(negedge clk);
    chk("midprog_busy", busy, 1);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    arr_out_ready = 0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_out_valid", arr_out_valid, 0);
    chk("mrst_ready", host_ready, 1);
    chk("mrst_done", xfer_done, 0);
    chk("mrst_en_b", ram_en_b, 0);
    chk("mrst_csum", xfer_csum, 0);
    ref_ptr = 0;
    exp_rv = 0;
    cyc();
    load_q.delete();
    for (int i = 0; i < 8; i++) load_q.push_back(8'($urandom));
    run_xfer(0, 8, 1, 32'h0, dc);
    chk("post_rst_load_done_cyc", dc, 8);
    host_rand(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
